// File: rtl/axis_bram_adapter_v1_0_pkg.sv
// Shared definitions for the AXIS/BRAM adapter job scheduler.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
// Contents: FSM state encoding and the transfer-direction constants.
package axis_bram_adapter_v1_0_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

endpackage

// File: rtl/axis_bram_adapter_v1_0_rr_arb.sv
// Two-requester round-robin arbiter (write vs. read) with a last-served register.
// Latency: winner is combinational from the requests; last-served updates one cycle after served_vld_i.
// Backpressure: none; the caller decides when a winner is actually taken.
// Ports: clk_i/rst_i clock and sync reset; wr_req_i/rd_req_i requests;
//        served_vld_i/served_dir_i record a finished job; any_req_o/win_dir_o selection result.
module axis_bram_adapter_v1_0_rr_arb
    import axis_bram_adapter_v1_0_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic wr_req_i,
    input  logic rd_req_i,
    input  logic served_vld_i,
    input  logic served_dir_i,
    output logic any_req_o,
    output logic win_dir_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        last_d = last_q;
        if (served_vld_i) begin
            last_d = served_dir_i;
        end
    end

    // Last-served starts as read so that write wins the first contested round.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= DIR_RD;
        end else begin
            last_q <= last_d;
        end
    end

    assign any_req_o = wr_req_i | rd_req_i;

    always_comb begin
        win_dir_o = DIR_RD;
        if (wr_req_i && rd_req_i) begin
            win_dir_o = ~last_q;
        end else if (wr_req_i) begin
            win_dir_o = DIR_WR;
        end
    end

endmodule

// File: rtl/axis_bram_adapter_v1_0_sched.sv
// Job scheduler: arbitrates write/read jobs, configures the adapter, counts beats to completion.
// Latency: grant one cycle after a request seen in IDLE, 2 TURN cycles, done one cycle after the last beat.
// Backpressure: requests outside IDLE are ignored (not queued); beats only count in RUN.
// Ports: clk/rst; wr_*/rd_* job requests; wr_grant/rd_grant, wr_done/rd_done pulses;
//        s_beat/m_beat stream beats; adp_rw/adp_index/adp_size adapter config; busy, err (timeout).
module axis_bram_adapter_v1_0_sched
    import axis_bram_adapter_v1_0_pkg::*;
#(
    parameter int BRAM_ADDR_LENGTH   = 9,
    parameter int BRAM_WIDTH_IN_WORD = 36,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_req,
    input  logic [BRAM_ADDR_LENGTH-1:0] wr_index,
    input  logic [BRAM_ADDR_LENGTH-1:0] wr_size,
    input  logic                        rd_req,
    input  logic [BRAM_ADDR_LENGTH-1:0] rd_index,
    input  logic [BRAM_ADDR_LENGTH-1:0] rd_size,
    output logic                        wr_grant,
    output logic                        rd_grant,
    output logic                        wr_done,
    output logic                        rd_done,
    input  logic                        s_beat,
    input  logic                        m_beat,
    output logic                        adp_rw,
    output logic [BRAM_ADDR_LENGTH-1:0] adp_index,
    output logic [BRAM_ADDR_LENGTH-1:0] adp_size,
    output logic                        busy,
    output logic                        err
);

    localparam int AL = BRAM_ADDR_LENGTH;
    localparam int WW = (BRAM_WIDTH_IN_WORD > 1) ? $clog2(BRAM_WIDTH_IN_WORD) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e          state_q, state_d;
    logic            turn_q, turn_d;
    logic [WW-1:0]   word_q, word_d;
    logic [AL-1:0]   row_q, row_d;
    logic [TW-1:0]   idle_q, idle_d;
    logic            rw_q, rw_d;
    logic [AL-1:0]   index_q, index_d;
    logic [AL-1:0]   size_q, size_d;
    logic            wr_grant_q, wr_grant_d;
    logic            rd_grant_q, rd_grant_d;
    logic            err_q, err_d;

    logic            any_req;
    logic            win_dir;
    logic            beat;
    logic            last_word;
    logic            last_beat;
    logic            timeout_hit;

    axis_bram_adapter_v1_0_rr_arb u_arb (
        .clk_i        (clk),
        .rst_i        (rst),
        .wr_req_i     (wr_req),
        .rd_req_i     (rd_req),
        .served_vld_i (state_q == ST_DONE),
        .served_dir_i (rw_q),
        .any_req_o    (any_req),
        .win_dir_o    (win_dir)
    );

    // Only the granted direction's beat counts, and only while running.
    assign beat        = (state_q == ST_RUN) && (rw_q ? s_beat : m_beat);
    assign last_word   = (word_q == WW'(BRAM_WIDTH_IN_WORD - 1));
    assign last_beat   = beat && last_word && (row_q == size_q);
    // Abort once TIMEOUT_CYCLES consecutive beat-less RUN cycles have elapsed.
    assign timeout_hit = (state_q == ST_RUN) && !beat && (idle_q == TW'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_req)                  state_d = ST_TURN;
            ST_TURN: if (turn_q)                   state_d = ST_RUN;
            ST_RUN:  if (last_beat || timeout_hit) state_d = ST_DONE;
            ST_DONE:                               state_d = ST_IDLE;
            default:                               state_d = ST_IDLE;
        endcase
    end

    // Counters and latched configuration
    always_comb begin
        turn_d     = turn_q;
        word_d     = word_q;
        row_d      = row_q;
        idle_d     = idle_q;
        rw_d       = rw_q;
        index_d    = index_q;
        size_d     = size_q;
        wr_grant_d = 1'b0;
        rd_grant_d = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    rw_d       = win_dir;
                    index_d    = (win_dir == DIR_WR) ? wr_index : rd_index;
                    size_d     = (win_dir == DIR_WR) ? wr_size  : rd_size;
                    wr_grant_d = (win_dir == DIR_WR);
                    rd_grant_d = (win_dir == DIR_RD);
                    turn_d     = 1'b0;
                    word_d     = '0;
                    row_d      = '0;
                    idle_d     = '0;
                end
            end
            ST_TURN: turn_d = 1'b1;
            ST_RUN: begin
                if (beat) begin
                    idle_d = '0;
                    if (last_word) begin
                        word_d = '0;
                        // Hold the row at size on the final beat so size = 2^AL-1 never wraps.
                        if (row_q != size_q) begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end else begin
                    idle_d = idle_q + 1'b1;
                end
                err_d = timeout_hit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            turn_q     <= 1'b0;
            word_q     <= '0;
            row_q      <= '0;
            idle_q     <= '0;
            rw_q       <= DIR_RD;
            index_q    <= '0;
            size_q     <= '0;
            wr_grant_q <= 1'b0;
            rd_grant_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            turn_q     <= turn_d;
            word_q     <= word_d;
            row_q      <= row_d;
            idle_q     <= idle_d;
            rw_q       <= rw_d;
            index_q    <= index_d;
            size_q     <= size_d;
            wr_grant_q <= wr_grant_d;
            rd_grant_q <= rd_grant_d;
            err_q      <= err_d;
        end
    end

    // Outputs
    always_comb begin
        busy      = (state_q != ST_IDLE);
        wr_done   = (state_q == ST_DONE) && (rw_q == DIR_WR);
        rd_done   = (state_q == ST_DONE) && (rw_q == DIR_RD);
        wr_grant  = wr_grant_q;
        rd_grant  = rd_grant_q;
        err       = err_q;
        adp_rw    = rw_q;
        adp_index = index_q;
        adp_size  = size_q;
    end

endmodule

// File: tb/tb_axis_bram_adapter_v1_0_sched.sv
// Self-checking bench for the adapter job scheduler (scoreboard of expected jobs).
// Latency: n/a.
// Backpressure: n/a.
module tb_axis_bram_adapter_v1_0_sched;

    localparam int AL = 9;
    localparam int W  = 36;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_req, rd_req;
    logic [AL-1:0] wr_index, wr_size, rd_index, rd_size;
    logic          wr_grant, rd_grant, wr_done, rd_done;
    logic          s_beat, m_beat;
    logic          adp_rw;
    logic [AL-1:0] adp_index, adp_size;
    logic          busy, err;

    axis_bram_adapter_v1_0_sched #(
        .BRAM_ADDR_LENGTH   (AL),
        .BRAM_WIDTH_IN_WORD (W),
        .TIMEOUT_CYCLES     (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_req    (wr_req),
        .wr_index  (wr_index),
        .wr_size   (wr_size),
        .rd_req    (rd_req),
        .rd_index  (rd_index),
        .rd_size   (rd_size),
        .wr_grant  (wr_grant),
        .rd_grant  (rd_grant),
        .wr_done   (wr_done),
        .rd_done   (rd_done),
        .s_beat    (s_beat),
        .m_beat    (m_beat),
        .adp_rw    (adp_rw),
        .adp_index (adp_index),
        .adp_size  (adp_size),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rw;
        int   idx;
        int   size;
    } job_t;

    job_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input logic rw, input int idx, input int size);
        job_t j;
        j.rw   = rw;
        j.idx  = idx;
        j.size = size;
        exp_q.push_back(j);
    endtask

    task automatic await_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (wr_grant || rd_grant) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("grant_timeout", 0, 1);
    endtask

    // Serve one job: stop_after>0 stops own beats after that many counted beats,
    // toggle_other wiggles the opposite-direction beat, rst_after>0 resets mid-job,
    // hold_req keeps the requests asserted after the grant.
    task automatic serve(input int stop_after, input bit toggle_other,
                         input int rst_after, input bit hold_req);
        job_t e;
        bit   ok, seen, own, oth;
        int   cyc, counted, idle;
        logic acc;
        await_grant(ok);
        if (!ok) return;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        chk("grant_dir", wr_grant, e.rw);
        chk("grant_excl", wr_grant & rd_grant, 0);
        chk("adp_rw", adp_rw, e.rw);
        chk("adp_index", adp_index, e.idx);
        chk("adp_size", adp_size, e.size);
        chk("busy_job", busy, 1);
        if (!hold_req) begin
            wr_req = 1'b0;
            rd_req = 1'b0;
        end
        cyc = 0; counted = 0; idle = 0; seen = 1'b0;
        while (!seen && cyc < 20000) begin
            own = (stop_after == 0) || (counted < stop_after);
            oth = toggle_other && (cyc % 2 == 1);
            s_beat = e.rw ? own : oth;
            m_beat = e.rw ? oth : own;
            tick();
            cyc++;
            // The first two edges after the grant fall in TURN and must not count.
            if (cyc >= 3) begin
                if (own) begin
                    counted++;
                    idle = 0;
                end else begin
                    idle++;
                end
            end
            if (wr_done || rd_done) seen = 1'b1;
            if (rst_after != 0 && counted == rst_after && !seen) begin
                s_beat = 1'b0;
                m_beat = 1'b0;
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk("rst_busy", busy, 0);
                chk("rst_gnt", {wr_grant, rd_grant}, 0);
                chk("rst_done", {wr_done, rd_done}, 0);
                chk("rst_err", err, 0);
                chk("rst_adp_rw", adp_rw, 0);
                chk("rst_adp_index", adp_index, 0);
                chk("rst_adp_size", adp_size, 0);
                acc = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    tick();
                    acc = acc | wr_done | rd_done | err | busy;
                end
                chk("abort_quiet", acc, 0);
                return;
            end
        end
        s_beat = 1'b0;
        m_beat = 1'b0;
        chk("done_seen", seen, 1);
        if (!seen) return;
        chk("done_dir", wr_done, e.rw);
        chk("done_excl", wr_done & rd_done, 0);
        chk("adp_hold", adp_index, e.idx);
        if (stop_after == 0) begin
            chk("beats", counted, (e.size + 1) * W);
            chk("err_clr", err, 0);
        end else begin
            chk("to_beats", counted, stop_after);
            chk("to_idle", idle, TO);
            chk("err_pulse", err, 1);
        end
        tick();
        chk("idle_after", busy, 0);
        chk("err_after", err, 0);
        chk("done_after", {wr_done, rd_done}, 0);
    endtask

    initial begin
        rst = 1'b1;
        wr_req = 1'b0; rd_req = 1'b0;
        wr_index = '0; wr_size = '0; rd_index = '0; rd_size = '0;
        s_beat = 1'b0; m_beat = 1'b0;
        tick(); tick(); tick();
        chk("reset_busy", busy, 0);
        chk("reset_adp", {adp_rw, adp_index, adp_size}, 0);
        chk("reset_pulses", {wr_grant, rd_grant, wr_done, rd_done, err}, 0);
        rst = 1'b0;
        tick();

        // Single write, two rows
        wr_index = 9'd4; wr_size = 9'd1; wr_req = 1'b1;
        post(1'b1, 4, 1);
        serve(0, 1'b0, 0, 1'b0);

        // Single-row read with the write-side beat toggling
        rd_index = 9'd7; rd_size = 9'd0; rd_req = 1'b1;
        post(1'b0, 7, 0);
        serve(0, 1'b1, 0, 1'b0);

        // Both requesting continuously: wr, rd, wr, rd
        wr_index = 9'd1; wr_size = 9'd0; rd_index = 9'd2; rd_size = 9'd0;
        wr_req = 1'b1; rd_req = 1'b1;
        post(1'b1, 1, 0); post(1'b0, 2, 0); post(1'b1, 1, 0); post(1'b0, 2, 0);
        serve(0, 1'b1, 0, 1'b1);
        serve(0, 1'b0, 0, 1'b1);
        serve(0, 1'b1, 0, 1'b1);
        serve(0, 1'b0, 0, 1'b0);

        // Timeout abort after 10 beats
        wr_index = 9'd3; wr_size = 9'd2; wr_req = 1'b1;
        post(1'b1, 3, 2);
        serve(10, 1'b0, 0, 1'b0);

        // Reset mid-job, then contested request: write must win again
        rd_index = 9'd5; rd_size = 9'd1; rd_req = 1'b1;
        post(1'b0, 5, 1);
        serve(0, 1'b0, 20, 1'b0);
        wr_index = 9'd6; wr_size = 9'd0; rd_index = 9'd9; rd_size = 9'd0;
        wr_req = 1'b1; rd_req = 1'b1;
        post(1'b1, 6, 0); post(1'b0, 9, 0);
        serve(0, 1'b1, 0, 1'b1);
        serve(0, 1'b0, 0, 1'b0);

        // Largest job: 512 rows
        wr_index = 9'd0; wr_size = 9'd511; wr_req = 1'b1;
        post(1'b1, 0, 511);
        serve(0, 1'b1, 0, 1'b0);

        chk("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_bram_adapter_v1_0_sched.md
AXIS_BRAM_ADAPTER_V1_0_SCHED -- requirements
Module: axis_bram_adapter_v1_0_sched

Interface
REQ-001 SHALL have parameter BRAM_ADDR_LENGTH, default 9, meaning BRAM row-address width (AL).
REQ-002 SHALL have parameter BRAM_WIDTH_IN_WORD, default 36, meaning stream words per BRAM row (W).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum number of consecutive beat-less RUN cycles.
REQ-004 SHALL use one clock and a synchronous active-high reset: clk in 1, the single clock; rst in 1, the synchronous active-high reset.
REQ-005 SHALL have ports wr_req in 1, wr_index in AL, wr_size in AL: write-job request, start row, and last-row offset.
REQ-006 SHALL have ports rd_req in 1, rd_index in AL, rd_size in AL: read-job request, start row, and last-row offset.
REQ-007 SHALL have ports wr_grant out 1, rd_grant out 1: one-cycle acceptance pulse per requester.
REQ-008 SHALL have ports wr_done out 1, rd_done out 1: one-cycle completion pulse per requester.
REQ-009 SHALL have ports s_beat in 1, meaning an input-stream word was accepted, and m_beat in 1, meaning an output-stream word was accepted.
REQ-010 SHALL have ports adp_rw out 1 (1=write to BRAM), adp_index out AL, adp_size out AL: adapter configuration.
REQ-011 SHALL have ports busy out 1 (state != IDLE) and err out 1 (timeout abort pulse).

Function
REQ-012 SHALL implement FSM states IDLE, TURN, RUN, DONE.
REQ-013 In IDLE with any request, SHALL select a winner, pulse its grant, latch its index/size into adp_index/adp_size, drive adp_rw, and enter TURN next cycle.
REQ-014 SHALL arbitrate round-robin on simultaneous wr_req and rd_req: winner = the requester not served last; last-served resets to read, so write wins first.
REQ-015 SHALL sample requests only in IDLE; requests in other states are ignored, not queued.
REQ-016 SHALL hold TURN exactly 2 cycles regardless of whether adp_rw changed, so the adapter's word counter restarts before beats are counted.
REQ-017 In RUN SHALL count only the beat of the granted direction (s_beat if write, m_beat if read); the other beat is ignored.
REQ-018 SHALL count with a word counter 0..W-1 and a row counter 0..size; word wraps to 0 and row increments at W-1.
REQ-019 SHALL leave RUN for DONE in the cycle after the beat at word W-1 of row == latched size, i.e. after exactly (size+1)*W beats.
REQ-020 DONE SHALL last 1 cycle, pulse the winner's done, update last-served, and return to IDLE; a new grant can issue at the earliest in the cycle after that.
REQ-021 SHALL reset an idle counter on every counted beat; on reaching TIMEOUT_CYCLES in RUN it SHALL pulse err together with DONE's done pulse (abort).
REQ-022 Counters SHALL not overflow for size = 2^AL-1; row counter width AL, word counter width clog2(W).
REQ-023 adp_rw/adp_index/adp_size SHALL hold their values from grant until the next grant.
REQ-024 Beats outside RUN SHALL have no effect.

Reset
REQ-025 On rst, SHALL enter IDLE, clear counters, set last-served=read, and drive all grant/done/err/busy=0, adp_rw=0, adp_index=0, adp_size=0 in the next cycle.
REQ-026 rst mid-job SHALL abort silently, with no done or err pulse; partial beats are discarded.

Structure
REQ-027 SHALL place the FSM state encoding and the direction constants (DIR_RD=0, DIR_WR=1) in the shared package axis_bram_adapter_v1_0_pkg.
REQ-028 SHALL place the two-requester round-robin arbiter in sub-module axis_bram_adapter_v1_0_rr_arb; counters and the FSM stay in the top level.

Verification
REQ-029 Single write, wr_index=4, wr_size=1: wr_grant pulses, adp_rw=1, adp_index=4, and wr_done pulses one cycle after the 72nd s_beat.
REQ-030 Simultaneous wr_req and rd_req held high after rst: the grant order is wr, rd, wr, rd.
REQ-031 Read with rd_size=0 and s_beat toggling: rd_done follows exactly 36 m_beats, and s_beat is ignored.
REQ-032 TIMEOUT_CYCLES=16, beats stop after 10: err and the done pulse assert together at the 16th beat-less cycle, then return to IDLE.
REQ-033 rst asserted mid-RUN after 20 beats: all outputs reset values next cycle, no done or err; a new job then completes normally.
REQ-034 wr_size=511: wr_done follows exactly 18432 beats, with no counter wrap error.
